// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS controller: FSM state
// encoding, opcode values and the aluop codes consumed by aludec.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } statetype_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_LW)   || (op == OP_SW)   || (op == OP_RTYPE) ||
               (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath strobe bundle. The controller is the master: it
// consumes the IR opcode and memory ready, and drives every enable/select.
interface mc_controller_if #(
    parameter int OPW  = 6,
    parameter int AOPW = 2
);
    logic [OPW-1:0]  op;
    logic            mem_ready;
    logic            memtoreg;
    logic            regdst;
    logic            iord;
    logic [1:0]      pcsrc;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic            irwrite;
    logic            memwrite;
    logic            pcwrite;
    logic            branch;
    logic            regwrite;
    logic [AOPW-1:0] aluop;
    logic            illegal_op;

    modport master (
        input  op, mem_ready,
        output memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
               memwrite, pcwrite, branch, regwrite, aluop, illegal_op
    );

    modport slave (
        output op, mem_ready,
        input  memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
               memwrite, pcwrite, branch, regwrite, aluop, illegal_op
    );
endinterface

// File: rtl/mc_controller.sv
// Moore main controller for the multicycle MIPS: sequences each instruction
// through 3-5 states, stretching memory states until mem_ready.
module mc_controller
    import mips_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 2
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);

    statetype_t      r_state;
    statetype_t      w_next_state;
    logic [OPW-1:0]  w_op;
    logic [AOPW-1:0] w_aluop;

    assign w_op = bus.op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:   w_next_state = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (w_op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = EXECUTE;
                    OP_BEQ:       w_next_state = BRANCH;
                    OP_ADDI:      w_next_state = ADDIEX;
                    OP_J:         w_next_state = JUMP;
                    default:      w_next_state = FETCH;
                endcase
            end
            // Only LW/SW can reach MEMADR; anything else falls back to FETCH.
            MEMADR: begin
                if (w_op == OP_LW) begin
                    w_next_state = MEMRD;
                end else if (w_op == OP_SW) begin
                    w_next_state = MEMWR;
                end else begin
                    w_next_state = FETCH;
                end
            end
            MEMRD:   w_next_state = bus.mem_ready ? MEMWB : MEMRD;
            MEMWB:   w_next_state = FETCH;
            MEMWR:   w_next_state = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE: w_next_state = ALUWB;
            ALUWB:   w_next_state = FETCH;
            BRANCH:  w_next_state = FETCH;
            ADDIEX:  w_next_state = ADDIWB;
            ADDIWB:  w_next_state = FETCH;
            JUMP:    w_next_state = FETCH;
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        bus.memtoreg   = 1'b0;
        bus.regdst     = 1'b0;
        bus.iord       = 1'b0;
        bus.pcsrc      = PCSRC_ALURES;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.irwrite    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.regwrite   = 1'b0;
        w_aluop        = AOPW'(ALUOP_ADD);
        bus.illegal_op = 1'b0;
        case (r_state)
            FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.illegal_op = !op_known(6'(w_op));
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                w_aluop     = AOPW'(ALUOP_FUNCT);
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                w_aluop     = AOPW'(ALUOP_SUB);
                bus.pcsrc   = PCSRC_ALUOUT;
                bus.branch  = 1'b1;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB: bus.regwrite = 1'b1;
            JUMP: begin
                bus.pcsrc   = PCSRC_JUMP;
                bus.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.aluop = w_aluop;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by
// cycle and compares the packed strobe vector against hand-derived values.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    mc_controller_if #(.OPW(6), .AOPW(2)) bus ();

    mc_controller #(.OPW(6), .AOPW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // {memtoreg, regdst, iord, pcsrc[1:0], alusrca, alusrcb[1:0], irwrite,
    //  memwrite, pcwrite, branch, regwrite, aluop[1:0], illegal_op}
    logic [15:0] obs;
    assign obs = {bus.memtoreg, bus.regdst, bus.iord, bus.pcsrc, bus.alusrca,
                  bus.alusrcb, bus.irwrite, bus.memwrite, bus.pcwrite,
                  bus.branch, bus.regwrite, bus.aluop, bus.illegal_op};

    localparam logic [15:0] E_FETCH   = 16'h01A0;
    localparam logic [15:0] E_FETCHW  = 16'h0100;
    localparam logic [15:0] E_DECODE  = 16'h0300;
    localparam logic [15:0] E_DECILL  = 16'h0301;
    localparam logic [15:0] E_MEMADR  = 16'h0600;
    localparam logic [15:0] E_MEMRD   = 16'h2000;
    localparam logic [15:0] E_MEMWB   = 16'h8008;
    localparam logic [15:0] E_MEMWR   = 16'h2040;
    localparam logic [15:0] E_EXECUTE = 16'h0404;
    localparam logic [15:0] E_ALUWB   = 16'h4008;
    localparam logic [15:0] E_BRANCH  = 16'h0C12;
    localparam logic [15:0] E_ADDIEX  = 16'h0600;
    localparam logic [15:0] E_ADDIWB  = 16'h0008;
    localparam logic [15:0] E_JUMP    = 16'h1020;

    task automatic test_reset();
        bus.op = 6'b000000;
        bus.mem_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH) $display("FAIL reset_fetch_ready: got %h want %h", obs, E_FETCH);
        else passed++;
        bus.mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== E_FETCHW) $display("FAIL reset_fetch_wait: got %h want %h", obs, E_FETCHW);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (obs !== E_FETCHW) $display("FAIL reset_held_clocked: got %h want %h", obs, E_FETCHW);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_lw();
        logic [15:0] e [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        bus.op = 6'b100011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL lw_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        logic [15:0] e [8] = '{E_FETCHW, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH};
        logic        r [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.op = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = r[i];
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL lw_stall_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 7) @(negedge clk);
        end
    endtask

    task automatic test_sw_wait();
        logic [15:0] e [7] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCH};
        logic        r [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          mw = 0;
        bus.op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = r[i];
            #1;
            if (bus.memwrite === 1'b1) mw++;
            total++;
            if (obs !== e[i]) $display("FAIL sw_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 6) @(negedge clk);
        end
        total++;
        if (mw !== 3) $display("FAIL sw_memwrite_cycles: got %0d want 3", mw);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [15:0] e [5] = '{E_FETCH, E_DECODE, E_EXECUTE, E_ALUWB, E_FETCH};
        bus.op = 6'b000000;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL rtype_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_beq();
        logic [15:0] e [4] = '{E_FETCH, E_DECODE, E_BRANCH, E_FETCH};
        bus.op = 6'b000100;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL beq_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_addi();
        logic [15:0] e [5] = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
        bus.op = 6'b001000;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL addi_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_jump();
        logic [15:0] e [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        bus.op = 6'b000010;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL jump_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] e [4] = '{E_FETCH, E_DECILL, E_FETCH, E_DECILL};
        bus.op = 6'b111111;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL illegal_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 3) @(negedge clk);
        end
        // Leave DECODE with a benign op so the next test starts in FETCH.
        bus.op = 6'b001010;
        @(negedge clk);
        #1;
        total++;
        if (obs !== E_FETCH) $display("FAIL illegal_return: got %h want %h", obs, E_FETCH);
        else passed++;
    endtask

    task automatic test_reset_mid_lw();
        bus.op = 6'b100011;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (obs !== E_MEMADR) $display("FAIL midlw_memadr: got %h want %h", obs, E_MEMADR);
        else passed++;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH) $display("FAIL midlw_async_reset: got %h want %h", obs, E_FETCH);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        bus.op = 6'b000010;
        @(negedge clk);
        #1;
        total++;
        if (obs !== E_DECODE) $display("FAIL midlw_resume_decode: got %h want %h", obs, E_DECODE);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (obs !== E_JUMP) $display("FAIL midlw_resume_jump: got %h want %h", obs, E_JUMP);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_memwr();
        logic [15:0] e [4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        logic        r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = r[i];
            #1;
            total++;
            if (obs !== e[i]) $display("FAIL swrst_cycle%0d: got %h want %h", i, obs, e[i]);
            else passed++;
            if (i < 3) @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus.memwrite !== 1'b0) $display("FAIL swrst_memwrite_drop: got %b want 0", bus.memwrite);
        else passed++;
        total++;
        if (obs !== E_FETCHW) $display("FAIL swrst_fetch: got %h want %h", obs, E_FETCHW);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH) $display("FAIL swrst_resume_fetch: got %h want %h", obs, E_FETCH);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (obs !== E_DECODE) $display("FAIL swrst_resume_decode: got %h want %h", obs, E_DECODE);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (obs !== E_FETCH) $display("FAIL swrst_complete: got %h want %h", obs, E_FETCH);
        else passed++;
    endtask

    initial begin
        bus.op = '0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_lw_stall();
        test_sw_wait();
        test_rtype();
        test_beq();
        test_addi();
        test_jump();
        test_illegal();
        test_reset_mid_lw();
        test_reset_in_memwr();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
